// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_pkg
//  Purpose  : Shared constants for the register scoreboard and the decode
//             logic that drives its source-use query inputs.
//             Contents:
//               REG_ADDR_W, NUM_REGS, ZERO_REG - register file geometry
//               JALR, BRANCH, OPIMM, OP, LOAD, STORE - major opcodes
//               src_use()                       - which sources an opcode reads
//  Revision : 1.0 - initial release
// ============================================================================
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_RS1     = 2'd1,
        SRC_RS1_RS2 = 2'd2
    } src_use_e;

    // Decode helper: i_rs1_used = (src_use(op) != SRC_NONE),
    // i_rs2_used = (src_use(op) == SRC_RS1_RS2).
    function automatic src_use_e src_use(input logic [6:0] opcode);
        case (opcode)
            JALR, LOAD, OPIMM: return SRC_RS1;
            BRANCH, STORE, OP: return SRC_RS1_RS2;
            default:           return SRC_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_entry.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_entry
//  Purpose  : One saturating up/down counter of outstanding writes for a
//             single architectural register.
//  Ports    : i_clk        clock, rising edge
//             i_rst_n      synchronous active-low reset
//             i_inc        one write issued this cycle
//             i_dec[1:0]   number of releases this cycle (writeback + kill)
//             o_busy       counter non-zero
//             o_one        counter equals one (used for writeback bypass)
//             o_err_over   increment attempted at the maximum count
//             o_err_under  release attempted below zero
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard_entry #(
    parameter int CNT_W = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic [1:0] i_dec,
    output logic       o_busy,
    output logic       o_one,
    output logic       o_err_over,
    output logic       o_err_under
);

    // Two guard bits: the top one flags a negative result, bit CNT_W flags
    // a result one above the maximum (the largest possible step is +1).
    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_sum       = {2'b00, r_cnt_q} + {{(SUM_W-1){1'b0}}, i_inc}
                    - {{CNT_W{1'b0}}, i_dec};
        w_cnt_d     = w_sum[CNT_W-1:0];
        o_err_over  = 1'b0;
        o_err_under = 1'b0;
        if (w_sum[SUM_W-1]) begin
            w_cnt_d     = '0;
            o_err_under = 1'b1;
        end else if (w_sum[CNT_W]) begin
            w_cnt_d     = '1;
            o_err_over  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_busy = |r_cnt_q;
    assign o_one  = (r_cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Tracks in-flight register writes (issue increments, writeback
//             and squash decrement) and answers decode's source-busy query.
//  Ports    : i_clk, i_rst_n          clock / synchronous active-low reset
//             i_issue_valid/_rd       destination registered at issue
//             i_wb_valid/_rd          destination released at writeback
//             i_kill_valid/_rd        destination released by squash
//             i_rs1_used/i_rs1        decode source 1 query
//             i_rs2_used/i_rs2        decode source 2 query
//             o_stall                 decode must hold (combinational)
//             o_busy_mask             per-register non-zero counters
//             o_overflow              sticky saturation error
//  Macro    : SCOREBOARD_WB_BYPASS_EN - a register whose only outstanding
//             write is being written back this cycle is reported not busy
//             to the stall query (o_busy_mask is unaffected).
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_issue_valid,
    input  logic [4:0]          i_issue_rd,
    input  logic                i_wb_valid,
    input  logic [4:0]          i_wb_rd,
    input  logic                i_kill_valid,
    input  logic [4:0]          i_kill_rd,
    input  logic                i_rs1_used,
    input  logic [4:0]          i_rs1,
    input  logic                i_rs2_used,
    input  logic [4:0]          i_rs2,
    output logic                o_stall,
    output logic [NUM_REGS-1:0] o_busy_mask,
    output logic                o_overflow
);

    import reg_scoreboard_pkg::*;

    logic [NUM_REGS-1:0] w_busy_mask;
    logic [NUM_REGS-1:0] w_err_over;
    logic [NUM_REGS-1:0] w_err_under;
`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [NUM_REGS-1:0] w_one;
    assign w_one[ZERO_REG] = 1'b0;
`endif

    logic r_overflow_q;
    logic w_overflow_d;
    logic w_rs1_busy;
    logic w_rs2_busy;

    // Register 0 has no counter: its events are dropped and it is never busy.
    assign w_busy_mask[ZERO_REG] = 1'b0;
    assign w_err_over[ZERO_REG]  = 1'b0;
    assign w_err_under[ZERO_REG] = 1'b0;

    for (genvar n = 1; n < NUM_REGS; n++) begin : g_entry
        logic       w_inc;
        logic       w_wb_hit;
        logic       w_kill_hit;
        logic [1:0] w_dec;

        assign w_inc      = i_issue_valid && (i_issue_rd == REG_ADDR_W'(n));
        assign w_wb_hit   = i_wb_valid    && (i_wb_rd    == REG_ADDR_W'(n));
        assign w_kill_hit = i_kill_valid  && (i_kill_rd  == REG_ADDR_W'(n));
        // Writeback and kill of the same register can both release.
        assign w_dec      = {1'b0, w_wb_hit} + {1'b0, w_kill_hit};

        reg_scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_inc       (w_inc),
            .i_dec       (w_dec),
            .o_busy      (w_busy_mask[n]),
`ifdef SCOREBOARD_WB_BYPASS_EN
            .o_one       (w_one[n]),
`else
            .o_one       (),
`endif
            .o_err_over  (w_err_over[n]),
            .o_err_under (w_err_under[n])
        );
    end

    always_comb begin
        w_rs1_busy = w_busy_mask[i_rs1];
        w_rs2_busy = w_busy_mask[i_rs2];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The register file is written before it is read, so the last
        // outstanding write landing this cycle already satisfies the read.
        if (i_wb_valid && (i_wb_rd == i_rs1) && w_one[i_rs1]) begin
            w_rs1_busy = 1'b0;
        end
        if (i_wb_valid && (i_wb_rd == i_rs2) && w_one[i_rs2]) begin
            w_rs2_busy = 1'b0;
        end
`endif
    end

    assign o_stall = (i_rs1_used && w_rs1_busy) || (i_rs2_used && w_rs2_busy);

    assign w_overflow_d = r_overflow_q | (|w_err_over) | (|w_err_under);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow_q <= 1'b0;
        end else begin
            r_overflow_q <= w_overflow_d;
        end
    end

    assign o_busy_mask = w_busy_mask;
    assign o_overflow  = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard: directed scenarios with
//             literal expectations followed by randomized traffic compared
//             every cycle against an integer-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    localparam int CNT_MAX = 3;  // 2^CNT_W - 1 for CNT_W = 2

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, wb_valid, kill_valid, rs1_used, rs2_used;
    logic [4:0]  issue_rd, wb_rd, kill_rd, rs1, rs2;
    logic        o_stall, o_overflow;
    logic [31:0] o_busy_mask;

    int model_cnt [32];
    bit model_ovf;
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .NUM_REGS(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_kill_valid  (kill_valid),
        .i_kill_rd     (kill_rd),
        .i_rs1_used    (rs1_used),
        .i_rs1         (rs1),
        .i_rs2_used    (rs2_used),
        .i_rs2         (rs2),
        .o_stall       (o_stall),
        .o_busy_mask   (o_busy_mask),
        .o_overflow    (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_busy(input int r);
        if (r == 0 || model_cnt[r] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (model_cnt[r] == 1 && wb_valid && int'(wb_rd) == r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = (model_cnt[r] != 0);
        return m;
    endfunction

    function automatic logic exp_stall();
        return (rs1_used && exp_busy(int'(rs1))) || (rs2_used && exp_busy(int'(rs2)));
    endfunction

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_mask",     o_busy_mask,       exp_mask());
            check("model_stall",    {31'b0, o_stall},  {31'b0, exp_stall()});
            check("model_overflow", {31'b0, o_overflow}, {31'b0, model_ovf});
        end
    end

    // Advance one clock edge and apply that edge's inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) model_cnt[r] = 0;
            model_ovf = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int v;
                v = model_cnt[r];
                if (issue_valid && int'(issue_rd) == r) v = v + 1;
                if (wb_valid    && int'(wb_rd)    == r) v = v - 1;
                if (kill_valid  && int'(kill_rd)  == r) v = v - 1;
                if (v < 0)       begin v = 0;       model_ovf = 1'b1; end
                if (v > CNT_MAX) begin v = CNT_MAX; model_ovf = 1'b1; end
                model_cnt[r] = v;
            end
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
        kill_valid = 0; kill_rd = 0; rs1_used = 0; rs1 = 0; rs2_used = 0; rs2 = 0;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic exp_t3;
        for (int r = 0; r < 32; r++) model_cnt[r] = 0;
        model_ovf = 1'b0;
        rst_n = 1'b0;
        idle();
        tick();
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;

        // Quiet after reset
        for (int i = 0; i < 10; i++) begin
            at_neg();
            check("rst_mask", o_busy_mask, 32'h0);
            check("rst_stall", {31'b0, o_stall}, 32'h0);
            check("rst_ovf", {31'b0, o_overflow}, 32'h0);
            tick();
        end

        // Issue rd=5, query rs1=5, writeback at t3
        issue_valid = 1; issue_rd = 5; rs1_used = 1; rs1 = 5;
        at_neg(); check("r5_stall_t0", {31'b0, o_stall}, 32'h0); tick();
        issue_valid = 0;
        at_neg(); check("r5_stall_t1", {31'b0, o_stall}, 32'h1); tick();
        at_neg(); check("r5_stall_t2", {31'b0, o_stall}, 32'h1); tick();
        wb_valid = 1; wb_rd = 5;
`ifdef SCOREBOARD_WB_BYPASS_EN
        exp_t3 = 1'b0;
`else
        exp_t3 = 1'b1;
`endif
        at_neg(); check("r5_stall_t3", {31'b0, o_stall}, {31'b0, exp_t3}); tick();
        wb_valid = 0;
        at_neg(); check("r5_stall_t4", {31'b0, o_stall}, 32'h0); tick();
        idle();

        // Two writes in flight to rd=7
        issue_valid = 1; issue_rd = 7; tick();
        tick();
        issue_valid = 0; wb_valid = 1; wb_rd = 7; tick();
        at_neg(); check("r7_busy_t3", {31'b0, o_busy_mask[7]}, 32'h1); tick();
        wb_valid = 0;
        at_neg(); check("r7_busy_t4", {31'b0, o_busy_mask[7]}, 32'h0); tick();

        // Register 0 is never tracked
        issue_valid = 1; issue_rd = 0; rs2_used = 1; rs2 = 0;
        at_neg(); check("r0_stall", {31'b0, o_stall}, 32'h0); check("r0_mask", o_busy_mask, 32'h0); tick();
        issue_valid = 0;
        at_neg();
        check("r0_mask_after", o_busy_mask, 32'h0);
        check("r0_stall_after", {31'b0, o_stall}, 32'h0);
        check("r0_ovf", {31'b0, o_overflow}, 32'h0);
        tick();
        idle();

        // rd=9: simultaneous issue/wb, kill, then an extra wb underflows
        issue_valid = 1; issue_rd = 9; tick();
        wb_valid = 1; wb_rd = 9; tick();
        idle();
        at_neg(); check("r9_same_cycle", o_busy_mask, 32'h200); tick();
        kill_valid = 1; kill_rd = 9; tick();
        idle();
        at_neg(); check("r9_kill_mask", o_busy_mask, 32'h0); check("r9_kill_ovf", {31'b0, o_overflow}, 32'h0); tick();
        wb_valid = 1; wb_rd = 9; tick();
        idle();
        at_neg(); check("r9_under_ovf", {31'b0, o_overflow}, 32'h1); check("r9_under_mask", o_busy_mask, 32'h0); tick();
        at_neg(); check("r9_ovf_sticky", {31'b0, o_overflow}, 32'h1); tick();

        // Saturation at rd=3
        rst_n = 0; tick(); rst_n = 1;
        at_neg(); check("sat_rst_ovf", {31'b0, o_overflow}, 32'h0); tick();
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1; issue_rd = 3; tick();
            idle();
            at_neg();
            if (i == 3) check("sat_ovf_3rd", {31'b0, o_overflow}, 32'h0);
            if (i == 4) begin
                check("sat_ovf_4th", {31'b0, o_overflow}, 32'h1);
                check("sat_mask_4th", o_busy_mask, 32'h8);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1; wb_rd = 3; tick();
            idle();
            at_neg();
            check("sat_drain", o_busy_mask, (i < 3) ? 32'h8 : 32'h0);
        end
        issue_valid = 1; issue_rd = 4; tick();
        idle();
        at_neg(); check("pre_rst_mask", o_busy_mask, 32'h10);
        rst_n = 0; issue_valid = 1; issue_rd = 6; wb_valid = 1; wb_rd = 4; tick();
        rst_n = 1; idle(); rs1_used = 1; rs1 = 4;
        at_neg();
        check("midrst_mask", o_busy_mask, 32'h0);
        check("midrst_stall", {31'b0, o_stall}, 32'h0);
        check("midrst_ovf", {31'b0, o_overflow}, 32'h0);
        tick();

        // Randomized traffic checked by the every-cycle comparison
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 249) != 0);
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            wb_valid    = $urandom_range(0, 1);
            wb_rd       = 5'($urandom_range(0, 7));
            kill_valid  = ($urandom_range(0, 3) == 0);
            kill_rd     = 5'($urandom_range(0, 7));
            rs1_used    = $urandom_range(0, 1);
            rs1         = 5'($urandom_range(0, 7));
            rs2_used    = $urandom_range(0, 1);
            rs2         = 5'($urandom_range(0, 7));
            tick();
        end
        rst_n = 1; idle();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Writer-side companion to the decode-stage stall check.
- Tracks every architectural register that has an in-flight write: destination registered at issue, released at writeback, optionally cancelled by squash.
- Answers per-cycle "source busy" queries for decode, so stall timing follows actual writeback rather than a fixed two-stage window; multi-cycle loads are handled.
- Sits beside the ID stage; issue comes from ID->EX, release from MEM->WB.

Parameters:
- CNT_W, 2, width of the per-register outstanding-write counter; maximum outstanding writes per register = 2^CNT_W-1.
- NUM_REGS, 32, number of architectural registers tracked; entry 0 is never tracked.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_issue_valid  input  1  an instruction with a register destination leaves ID this cycle.
- i_issue_rd  input  5  destination register of the issuing instruction.
- i_wb_valid  input  1  a register write commits this cycle.
- i_wb_rd  input  5  register being written back.
- i_kill_valid  input  1  an issued-but-not-written instruction is squashed.
- i_kill_rd  input  5  destination of the squashed instruction.
- i_rs1_used  input  1  decode instruction reads rs1.
- i_rs1  input  5  rs1 number.
- i_rs2_used  input  1  decode instruction reads rs2.
- i_rs2  input  5  rs2 number.
- o_stall  output  1  decode must hold; combinational from counters and query inputs.
- o_busy_mask  output  32  bit n = 1 when counter[n] != 0; bit 0 is always 0.
- o_overflow  output  1  sticky error flag.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all counters = 0, o_overflow = 0; o_busy_mask = 0 and o_stall = 0 follow from that. Reset takes effect mid-operation regardless of other inputs; no pending state survives.
- Per register n, each cycle: inc = issue_valid && issue_rd==n; dec = (wb_valid && wb_rd==n) + (kill_valid && kill_rd==n). next = cnt + inc - dec.
  - Writeback and kill of the same register in one cycle may both decrement.
  - Simultaneous issue and writeback of the same register: count unchanged.
- Register 0: all events ignored; its counter stays 0.
- Saturation:
  - inc when cnt == max and no dec: counter holds at max, o_overflow set.
  - dec when cnt == 0: counter holds at 0, o_overflow set.
  - o_overflow clears only on reset.
- busy(r) = r != 0 && cnt[r] != 0, evaluated on the registered counter values.
- o_stall = (i_rs1_used && busy(i_rs1)) || (i_rs2_used && busy(i_rs2)).
- Latency:
  - Issue in cycle t makes the register busy from cycle t+1.
  - Writeback in cycle t clears busy from cycle t+1; same-cycle release only with the optional feature.
- Issue while o_stall = 1 is the pipeline's responsibility to suppress. The scoreboard counts whatever is presented.

Optional Feature:
- Macro SCOREBOARD_WB_BYPASS_EN.
- When defined: busy(r) additionally masks a same-cycle release. A register with cnt == 1 and an active writeback (i_wb_valid && i_wb_rd == r) reports not busy, removing one stall cycle when the register file writes before it is read.
- When undefined: busy(r) uses registered counters only, as above.
- o_busy_mask always reflects registered counters in both modes.

Decomposition:
- Shared package:
  - REG_ADDR_W = 5, NUM_REGS = 32, ZERO_REG = 0.
  - opcode constants JALR, BRANCH, OPIMM, OP, LOAD, STORE, used by ID to derive i_rs1_used/i_rs2_used.
- Sub-module scoreboard_entry:
  - one saturating up/down counter of CNT_W bits, inputs inc, dec[1:0].
  - outputs busy, err_over, err_under.
  - instantiated NUM_REGS-1 times via generate.
- Top level holds the event decode, the query muxes and the sticky error.

Test Plan:
- Reset release, no events -> o_busy_mask = 0, o_stall = 0, o_overflow = 0 for 10 cycles.
- Issue rd=5 at t0; query rs1=5, rs1_used=1 -> o_stall = 0 at t0, 1 at t1; wb rd=5 at t3 -> o_stall = 0 at t4 (at t3 when SCOREBOARD_WB_BYPASS_EN).
- Issue rd=7 twice (t0, t1); wb rd=7 at t2 -> still busy at t3; second wb at t3 -> o_busy_mask[7] = 0 at t4.
- Issue rd=0 and query rs2=0 with rs2_used=1 -> o_stall = 0, o_busy_mask = 0, o_overflow = 0.
- Same cycle: issue rd=9 and wb rd=9 with cnt[9]=1 -> cnt[9] stays 1; kill rd=9 next cycle -> busy clears; extra wb rd=9 -> o_overflow = 1 (sticky), counter stays 0.
- CNT_W=2: 4 issues to rd=3 without wb -> o_overflow = 1 after the 4th, counter = 3; assert i_rst_n=0 for one edge -> all outputs 0.
